// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encoding, shifter states, data-length decode.
// Used by the configurable transmitter and the matching receiver.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam int unsigned MIN_DIV = 2;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    // 0..3 selects 5..8 data bits, never more than the data path width.
    function automatic int unsigned data_len(input logic [1:0] code, input int unsigned max_len);
        int unsigned n;
        n = 32'(code) + 32'd5;
        return (n > max_len) ? max_len : n;
    endfunction

    function automatic logic parity_en(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Byte handshake, runtime configuration and line/status signals of the UART transmitter.
interface uart_tx_cfg_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 16
);
    logic [DIV_W-1:0]  div;
    logic [1:0]        data_bits;
    logic [1:0]        parity_mode;
    logic              stop2;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (
        output div, data_bits, parity_mode, stop2, tx_valid, tx_data,
        input  tx_ready, tx, busy, done
    );

    modport slave (
        input  div, data_bits, parity_mode, stop2, tx_valid, tx_data,
        output tx_ready, tx, busy, done
    );
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..div_i-1 while enabled, tick_o marks the last cycle of a bit.
module uart_baud_cnt #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == div_i - DIV_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with a one-entry holding register so that
// back-to-back frames leave the shifter with no idle gap.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 16
) (
    input logic          clk,
    input logic          rst,
    uart_tx_cfg_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DATA_W);

    uart_state_t       state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [IDX_W-1:0]  last_idx_q, last_idx_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              stop_idx_q, stop_idx_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;

    logic              tick, accept, last_stop, xfer;
    logic [DATA_W-1:0] mask;
    int unsigned       n_new;
    logic [DIV_W-1:0]  div_new;

    uart_baud_cnt #(
        .DIV_W (DIV_W)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (xfer || (state_q == ST_IDLE)),
        .en_i   (state_q != ST_IDLE),
        .div_i  (div_q),
        .tick_o (tick)
    );

    assign accept    = bus.tx_valid && !hold_full_q;
    assign last_stop = (state_q == ST_STOP) && tick && (stop_idx_q == stop2_q);
    assign xfer      = hold_full_q && ((state_q == ST_IDLE) || last_stop);
    assign div_new   = (bus.div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : bus.div;

    always_comb begin
        n_new = data_len(bus.data_bits, DATA_W);
        for (int unsigned i = 0; i < DATA_W; i++) begin
            mask[i] = (i < n_new);
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        div_d       = div_q;
        last_idx_d  = last_idx_q;
        bit_idx_d   = bit_idx_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop2_d     = stop2_q;
        stop_idx_d  = stop_idx_q;
        tx_d        = tx_q;
        done_d      = 1'b0;

        if (accept) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: tx_d = 1'b1;
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == last_idx_q) begin
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d    = ST_STOP;
                            stop_idx_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            ST_STOP: begin
                if (last_stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    tx_d    = 1'b1;
                end else if (tick) begin
                    stop_idx_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Transfer wins over the IDLE return so the next start bit follows the stop bit directly.
        if (xfer) begin
            state_d     = ST_START;
            tx_d        = 1'b0;
            hold_full_d = 1'b0;
            shift_d     = hold_q & mask;
            div_d       = div_new;
            last_idx_d  = IDX_W'(n_new - 32'd1);
            par_en_d    = parity_en(bus.parity_mode);
            par_bit_d   = (^(hold_q & mask)) ^ (bus.parity_mode == PAR_ODD);
            stop2_d     = bus.stop2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            div_q       <= DIV_W'(MIN_DIV);
            last_idx_q  <= '0;
            bit_idx_q   <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop2_q     <= 1'b0;
            stop_idx_q  <= 1'b0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            div_q       <= div_d;
            last_idx_q  <= last_idx_d;
            bit_idx_q   <= bit_idx_d;
            par_en_q    <= par_en_d;
            par_bit_q   <= par_bit_d;
            stop2_q     <= stop2_d;
            stop_idx_q  <= stop_idx_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.tx_ready = !hold_full_q;
    assign bus.busy     = (state_q != ST_IDLE) || hold_full_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed test-plan frames plus randomized frames
// compared cycle by cycle against a frame-level line model.
module tb_uart_tx_cfg;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    typedef struct {
        logic [15:0] bits;
        int          len;
        int          dv;
    } frame_t;

    frame_t exp_q[$];

    uart_tx_cfg_if #(.DATA_W(8), .DIV_W(16)) bus ();

    uart_tx_cfg #(
        .DATA_W (8),
        .DIV_W  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line levels for one frame, in transmission order.
    function automatic frame_t make_frame(input logic [7:0] d, input int db, input int pm,
                                          input int s2, input int dv);
        frame_t fr;
        int n, k, ones;
        n = 5 + db;
        if (n > 8) n = 8;
        fr.bits = '0;
        fr.dv   = (dv < 2) ? 2 : dv;
        ones    = 0;
        fr.bits[0] = 1'b0;
        k = 1;
        for (int i = 0; i < n; i++) begin
            fr.bits[k] = d[i];
            ones += int'(d[i]);
            k++;
        end
        if (pm == 1) begin
            fr.bits[k] = ((ones % 2) == 1);
            k++;
        end else if (pm == 2) begin
            fr.bits[k] = ((ones % 2) == 0);
            k++;
        end
        for (int i = 0; i < ((s2 != 0) ? 2 : 1); i++) begin
            fr.bits[k] = 1'b1;
            k++;
        end
        fr.len = k;
        return fr;
    endfunction

    task automatic send(input logic [7:0] d, input int db, input int pm, input int s2,
                        input int dv, input bit keep);
        int w;
        @(negedge clk);
        bus.tx_data     = d;
        bus.data_bits   = 2'(db);
        bus.parity_mode = 2'(pm);
        bus.stop2       = 1'(s2);
        bus.div         = 16'(dv);
        bus.tx_valid    = 1'b1;
        w = 0;
        while (bus.tx_ready !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (bus.tx_ready !== 1'b1) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            bus.tx_valid = 1'b0;
            return;
        end
        acc_cyc = cyc + 1;
        exp_q.push_back(make_frame(d, db, pm, s2, dv));
        @(posedge clk);
        if (!keep) begin
            @(negedge clk);
            bus.tx_valid = 1'b0;
        end
    endtask

    task automatic mon_frames(input int nfr);
        frame_t fr;
        int ok_cnt, dn_bad, exp_busy;
        bit got;
        got = 1'b0;
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (bus.tx === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check_eq("start_timeout", 32'd0, 32'd1);
            return;
        end
        check_eq("start_latency", cyc, acc_cyc + 1);
        for (int f = 0; f < nfr; f++) begin
            if (exp_q.size() == 0) begin
                check_eq("exp_empty", 32'd0, 32'd1);
                return;
            end
            fr = exp_q.pop_front();
            dn_bad = 0;
            for (int b = 0; b < fr.len; b++) begin
                ok_cnt = 0;
                for (int c = 0; c < fr.dv; c++) begin
                    if (bus.tx === fr.bits[b]) ok_cnt++;
                    if (!(f > 0 && b == 0 && c == 0) && bus.done !== 1'b0) dn_bad++;
                    @(negedge clk);
                end
                check_eq($sformatf("f%0d_bit%0d", f, b), ok_cnt, fr.dv);
            end
            exp_busy = (f < nfr - 1) ? 1 : 0;
            check_eq("done_quiet", dn_bad, 32'd0);
            check_eq("done_pulse", 32'(bus.done), 32'd1);
            check_eq("ready_at_done", 32'(bus.tx_ready), 32'd1);
            check_eq("busy_at_done", 32'(bus.busy), exp_busy);
        end
        check_eq("idle_tx", 32'(bus.tx), 32'd1);
        @(negedge clk);
        check_eq("done_once", 32'(bus.done), 32'd0);
    endtask

    task automatic scramble_cfg();
        bus.div         = 16'($urandom_range(0, 6));
        bus.data_bits   = 2'($urandom_range(0, 3));
        bus.parity_mode = 2'($urandom_range(0, 3));
        bus.stop2       = 1'($urandom_range(0, 1));
    endtask

    task automatic run_single(input logic [7:0] d, input int db, input int pm, input int s2,
                              input int dv, input bit scramble);
        fork
            begin
                send(d, db, pm, s2, dv, 1'b0);
                if (scramble) begin
                    repeat (3) @(negedge clk);
                    scramble_cfg();
                end
            end
            mon_frames(1);
        join
    endtask

    task automatic run_pair(input logic [7:0] d1, input logic [7:0] d2, input int db,
                            input int pm, input int s2, input int dv);
        fork
            begin
                send(d1, db, pm, s2, dv, 1'b1);
                send(d2, db, pm, s2, dv, 1'b0);
            end
            mon_frames(2);
        join
    endtask

    initial begin
        int zero_cnt, done_cnt, mode;
        rst             = 1'b1;
        bus.tx_valid    = 1'b0;
        bus.tx_data     = '0;
        bus.div         = 16'd4;
        bus.data_bits   = 2'd3;
        bus.parity_mode = 2'd0;
        bus.stop2       = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", 32'(bus.tx), 32'd1);
        check_eq("rst_ready", 32'(bus.tx_ready), 32'd1);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_single(8'hA5, 3, 0, 0, 4, 1'b0);
        run_single(8'h35, 2, 1, 1, 3, 1'b0);
        run_single(8'hFF, 0, 2, 0, 2, 1'b0);
        run_pair(8'h01, 8'h80, 3, 0, 0, 4);
        run_single(8'h5C, 3, 1, 0, 0, 1'b0);
        run_single(8'h5C, 3, 1, 0, 1, 1'b0);
        run_single(8'h96, 1, 3, 1, 5, 1'b1);
        run_single(8'h6B, 2, 2, 0, 3, 1'b0);

        // Reset ten cycles into a frame while a second byte is held.
        send(8'h55, 3, 0, 0, 4, 1'b1);
        send(8'hC3, 3, 0, 0, 4, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_tx", 32'(bus.tx), 32'd1);
        check_eq("midrst_ready", 32'(bus.tx_ready), 32'd1);
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        exp_q.delete();
        done_cnt = 0;
        zero_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done !== 1'b0) done_cnt++;
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done !== 1'b0) done_cnt++;
            if (bus.tx !== 1'b1) zero_cnt++;
        end
        check_eq("midrst_no_done", done_cnt, 32'd0);
        check_eq("midrst_line_idle", zero_cnt, 32'd0);
        check_eq("midrst_ready_after", 32'(bus.tx_ready), 32'd1);
        run_single(8'h3C, 3, 0, 0, 4, 1'b0);

        for (int it = 0; it < 24; it++) begin
            mode = $urandom_range(0, 2);
            if (mode == 2) begin
                run_pair(8'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 1), $urandom_range(0, 6));
            end else begin
                run_single(8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                           $urandom_range(0, 1), $urandom_range(0, 6), mode == 1);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised, runtime-configurable UART transmitter and the successor to the fixed 8N1 transmitter in the serial service path. It accepts bytes over a valid/ready handshake into a one-entry holding register, so back-to-back frames go out with no idle gap. It serialises each byte with a configurable data length, parity and stop-bit count at a runtime-programmable bit period. It sits between the service/debug logic and the board TX pin.

## Interface
- DATA_W, 8: width of tx_data; also the maximum data length.
- DIV_W, 16: width of the bit-period divisor.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- div  in  DIV_W  clocks per bit; values <2 are treated as 2.
- data_bits  in  2  data length: 0=5, 1=6, 2=7, 3=8 bits; capped at DATA_W.
- parity_mode  in  2  0=none, 1=even, 2=odd, 3=none (reserved).
- stop2  in  1  0=one stop bit, 1=two stop bits.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  holding register empty; byte accepted on the edge where tx_valid&tx_ready.
- tx_data  in  DATA_W  byte to send.
- tx  out  1  serial line; idle high.
- busy  out  1  a frame is on the line, or the holding register is full.
- done  out  1  one-cycle pulse at end of each frame.

## Operation
- Reset values: tx=1, tx_ready=1, busy=0, done=0, state=IDLE, holding register empty, counters 0.
- Reset asserted mid-frame: tx returns high immediately. The frame in progress and any held byte are discarded. No done pulse is produced.
- Holding register: loads tx_data on accept. It transfers to the shifter on the edge where the shifter is in IDLE, or on the edge ending the last stop-bit cycle.
- Configuration snapshot: div, data_bits, parity_mode and stop2 are captured into the shifter at transfer. Changing them mid-frame has no effect on that frame.
- Shifter state machine: IDLE -> START -> DATA (N bits, LSB first) -> PARITY (only if parity enabled) -> STOP (1 or 2 bits) -> IDLE, or directly START if the holding register is full.
- Line levels: start bit 0, stop bits 1.
- Parity bit:
  - even: XOR of the N data bits.
  - odd: inverse of that XOR.
  - Data bits above N are ignored for both transmission and parity.
- Bit timing: each bit holds for exactly div_snapshot cycles. Bit counter runs 0..div-1; bit index counter runs 0..N-1.
- Frame length: div*(1+N+P+S) cycles, where P is 0/1 and S is 1/2.

## Timing
- Accept at edge T with shifter IDLE:
  - Holding register loads at T.
  - Transfer happens at T+1; tx is low from T+1 (one-cycle latency to start bit).
  - tx_ready is low for the cycle after T and high again after T+1.
- tx is registered: every level change occurs on a clk edge, never combinationally from inputs.
- done: high for exactly one cycle, the cycle following the final stop-bit cycle.
- Back-to-back: if the holding register is full at the end of stop, the next start bit begins on the same edge. done still pulses, and tx_ready rises the following cycle.
- Simultaneous transfer-out and new accept on the same edge: not possible, because tx_ready is low while the holding register is full. tx_valid held high with tx_ready low is simply waiting; nothing is lost.
- busy falls in the same cycle done rises when no byte is held.

## Structure
- Package uart_pkg:
  - Parity-mode encoding constants (PAR_NONE, PAR_EVEN, PAR_ODD).
  - Data-length decode function.
  - Shifter state enum (IDLE, START, DATA, PARITY, STOP).
  - Minimum divisor constant (2).
  - Shared with the future uart_rx_cfg.
- Sub-module uart_baud_cnt:
  - Loadable bit-period counter with a tick output on the last cycle of each bit.
  - Clear input.
  - Reusable by the receiver.

## Test plan
- 8N1, div=4: send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; 40-cycle frame; done pulses once at cycle 41 after start.
- 7E2, div=3: send 0x35 -> data 1,0,1,0,1,1,0; parity 0; stops 1,1; 33-cycle frame.
- 5O1, div=2: send 0xFF -> data 1,1,1,1,1; parity 0; bits 5-7 ignored; frame 16 cycles.
- Back-to-back 0x01 then 0x80 with tx_valid held high, div=4 -> second start bit immediately follows first stop bit with no idle cycle; tx_ready low only while a byte is held.
- Reset asserted at cycle 10 of an 8N1 frame with a byte held -> tx=1 and tx_ready=1 immediately; no done pulse; next accept produces a clean frame.
- div=0 and div=1 -> behaves identically to div=2; div or config changed mid-frame -> current frame unchanged, next frame uses the new values.
